// File: rtl/lsnn_pkg.sv
// Shared definitions for the LSNN neuron array.
// Contents:
//   state_t : step sequencer states (IDLE, RUN, DONE)
//   sat_add : unsigned add clamped to 2^w-1, evaluated on 32-bit operands
package lsnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Callers zero-extend W-bit operands to 32 bits and cast the result back to W bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << w) - 33'd1;
        return 32'((sum > max_val) ? max_val : sum);
    endfunction

endpackage

// File: rtl/lsnn_lif_update.sv
// Combinational single-neuron adaptive LIF update, shared across the array.
// Ports:
//   v_cur, a_cur, ref_cur : pre-step membrane, adaptation and refractory count
//   i_cur                 : input current for this step
//   v_next, a_next, ref_next : post-step state
//   spike                 : neuron fired this step
module lsnn_lif_update
    import lsnn_pkg::*;
#(
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int B0         = 8,
    parameter int UP_SHIFT   = 2,
    parameter int DN_SHIFT   = 2,
    parameter int REFRAC     = 2,
    parameter int REF_W      = 2
) (
    input  logic [W-1:0]     v_cur,
    input  logic [W-1:0]     a_cur,
    input  logic [W-1:0]     i_cur,
    input  logic [REF_W-1:0] ref_cur,
    output logic [W-1:0]     v_next,
    output logic [W-1:0]     a_next,
    output logic [REF_W-1:0] ref_next,
    output logic             spike
);

    logic [W-1:0] thr;
    logic [W-1:0] v_leak;
    logic [W-1:0] v_int;
    logic [W-1:0] a_up;
    logic [W-1:0] a_dn;

    assign thr    = W'(sat_add(32'(B0), 32'(a_cur), W));
    // V - (V >> s) never underflows, so only the current add needs clamping.
    assign v_leak = v_cur - (v_cur >> LEAK_SHIFT);
    assign v_int  = W'(sat_add(32'(v_leak), 32'(i_cur), W));
    assign a_up   = W'(sat_add(32'(a_cur), 32'(a_cur >> UP_SHIFT), W));
    assign a_dn   = a_cur - (a_cur >> DN_SHIFT);

    always_comb begin
        v_next   = v_int;
        a_next   = a_dn;
        ref_next = ref_cur;
        spike    = 1'b0;
        if (ref_cur != '0) begin
            // Refractory: input ignored, membrane held at zero, adaptation keeps decaying.
            v_next   = '0;
            ref_next = ref_cur - REF_W'(1);
        end else if (v_int >= thr) begin
            spike    = 1'b1;
            v_next   = '0;
            a_next   = a_up;
            ref_next = REF_W'(REFRAC);
        end
    end

endmodule

// File: rtl/lsnn_neuron_array.sv
// Time-multiplexed array of N adaptive LIF neurons sharing one update datapath.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   step_valid/step_ready  : step request handshake (ready only in IDLE)
//   i_current              : per-neuron current, neuron k at [k*W +: W], captured at accept
//   spike_out, spike_valid : spike vector of the last step and its one-cycle update pulse
//   busy                   : step in progress
//   thr_sel, thr_out       : combinational threshold read of one neuron (0 if out of range)
module lsnn_neuron_array
    import lsnn_pkg::*;
#(
    parameter int N_NEURONS  = 4,
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int B0         = 8,
    parameter int ALPHA      = 8,
    parameter int UP_SHIFT   = 2,
    parameter int DN_SHIFT   = 2,
    parameter int REFRAC     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         step_valid,
    output logic                         step_ready,
    input  logic [N_NEURONS*W-1:0]       i_current,
    output logic [N_NEURONS-1:0]         spike_out,
    output logic                         spike_valid,
    output logic                         busy,
    input  logic [$clog2(N_NEURONS)-1:0] thr_sel,
    output logic [W-1:0]                 thr_out
);

    localparam int IDX_W = $clog2(N_NEURONS);
    localparam int REF_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       idx;
    logic [N_NEURONS*W-1:0] i_reg;
    logic [W-1:0]           v_mem   [N_NEURONS];
    logic [W-1:0]           a_mem   [N_NEURONS];
    logic [REF_W-1:0]       ref_mem [N_NEURONS];
    logic [N_NEURONS-1:0]   spike_acc;
    logic [N_NEURONS-1:0]   spike_vec;
    logic [W-1:0]           v_sel;
    logic [W-1:0]           a_sel;
    logic [W-1:0]           i_sel;
    logic [REF_W-1:0]       ref_sel;
    logic [W-1:0]           v_upd;
    logic [W-1:0]           a_upd;
    logic [REF_W-1:0]       ref_upd;
    logic                   spike_upd;
    logic [W-1:0]           thr_a;
    logic                   thr_hit;
    logic                   accept;

    assign step_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign accept     = step_valid && step_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Selects the state of neuron idx and merges its spike into the partial vector.
    always_comb begin
        v_sel     = '0;
        a_sel     = '0;
        i_sel     = '0;
        ref_sel   = '0;
        spike_vec = spike_acc;
        for (int k = 0; k < N_NEURONS; k++) begin
            if (idx == IDX_W'(k)) begin
                v_sel        = v_mem[k];
                a_sel        = a_mem[k];
                i_sel        = i_reg[k*W +: W];
                ref_sel      = ref_mem[k];
                spike_vec[k] = spike_upd;
            end
        end
    end

    lsnn_lif_update #(
        .W          (W),
        .LEAK_SHIFT (LEAK_SHIFT),
        .B0         (B0),
        .UP_SHIFT   (UP_SHIFT),
        .DN_SHIFT   (DN_SHIFT),
        .REFRAC     (REFRAC),
        .REF_W      (REF_W)
    ) u_update (
        .v_cur    (v_sel),
        .a_cur    (a_sel),
        .i_cur    (i_sel),
        .ref_cur  (ref_sel),
        .v_next   (v_upd),
        .a_next   (a_upd),
        .ref_next (ref_upd),
        .spike    (spike_upd)
    );

    // spike_out and spike_valid are loaded as the last neuron retires, so both
    // are visible during the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            i_reg       <= '0;
            spike_acc   <= '0;
            spike_out   <= '0;
            spike_valid <= 1'b0;
            for (int k = 0; k < N_NEURONS; k++) begin
                v_mem[k]   <= '0;
                a_mem[k]   <= W'(ALPHA);
                ref_mem[k] <= '0;
            end
        end else begin
            spike_valid <= 1'b0;
            if (accept) begin
                idx       <= '0;
                i_reg     <= i_current;
                spike_acc <= '0;
            end else if (state == RUN) begin
                v_mem[idx]   <= v_upd;
                a_mem[idx]   <= a_upd;
                ref_mem[idx] <= ref_upd;
                spike_acc    <= spike_vec;
                if (idx == LAST_IDX) begin
                    spike_out   <= spike_vec;
                    spike_valid <= 1'b1;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    // Threshold observation port; an unmatched select yields zero.
    always_comb begin
        thr_a   = '0;
        thr_hit = 1'b0;
        for (int k = 0; k < N_NEURONS; k++) begin
            if (thr_sel == IDX_W'(k)) begin
                thr_a   = a_mem[k];
                thr_hit = 1'b1;
            end
        end
    end

    assign thr_out = thr_hit ? W'(sat_add(32'(B0), 32'(thr_a), W)) : '0;

endmodule
